pipelined_data_memory: RTL
==========================

Name: pipelined_data_memory

Overview:
- Parametrised successor to the processor's single-port data memory: word-organised RAM plus a load/store front end with a valid/ready request handshake.
- Supports byte, halfword and word accesses with sign or zero extension, and a configurable read latency.
- Sits in the MEM stage of the pipeline. req_ready low tells hazard logic to stall the MEM stage.

Parameters:
- DATA_W, 32: data word width. Fixed at 32 for byte-lane logic; other values are illegal.
- DEPTH, 1024: number of words. Power of 2, at least 4.
- ADDR_W, 32: request address width, byte address.
- RD_LATENCY, 1: cycles from read acceptance to rsp_valid. Legal range 1..4.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request this cycle.
- req_write, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 00 byte, 01 halfword, 10 word. 11 is treated as word.
- req_unsigned, in, 1: load zero-extends when 1, sign-extends when 0.
- req_addr, in, ADDR_W: byte address.
- req_wdata, in, DATA_W: store data, right-aligned (byte in [7:0], halfword in [15:0]).
- rsp_valid, out, 1: one-cycle pulse marking completion.
- rsp_rdata, out, DATA_W: load result, valid only while rsp_valid is high.
- rsp_err, out, 1: misaligned access flag. Tied to 0 unless DMEM_MISALIGN_EN is defined.

Behaviour:
- Reset:
  - FSM returns to IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - Memory contents are not cleared.
  - An in-flight read is dropped and produces no response.
- Acceptance: a request is accepted on a clock edge where req_valid && req_ready. At most one request is outstanding.
- Addressing:
  - Word index is req_addr[log2(DEPTH)+1:2]; byte lane is req_addr[1:0].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH.
- FSM states and transitions:
  - IDLE: req_ready=1. Accepted store goes to WRESP. Accepted load goes to RWAIT with cnt=RD_LATENCY-1; if RD_LATENCY=1 it goes straight to RRESP.
  - RWAIT: req_ready=0. cnt decrements each cycle. At cnt=1 go to RRESP.
  - RRESP: rsp_valid=1 and rsp_rdata=extended load. Go to IDLE. req_ready=0 in this cycle.
  - WRESP: rsp_valid=1, rsp_rdata=0. Go to IDLE. req_ready=0 in this cycle.
- Load latency: rsp_valid rises exactly RD_LATENCY cycles after the accepting edge. Back-to-back loads are spaced RD_LATENCY+1 cycles apart.
- Stores:
  - Memory is updated on the accepting edge.
  - Only the addressed lanes are written: byte uses lane addr[1:0]; halfword uses lanes {addr[1],0}/{addr[1],1}; word writes all 4 lanes.
  - rsp_valid pulses on the next cycle.
- Read data capture: the memory word is sampled on the accepting edge and carried through the latency pipe. A load issued after a store completes always sees the stored data.
- Misalignment without the macro: halfword ignores addr[0]; word ignores addr[1:0].
- Load extension: the selected byte or halfword is shifted down to bit 0, then extended with bit 7 or bit 15 (signed), or with zeros (unsigned).
- req_valid sampled while req_ready=0 is ignored. The requester must hold the request stable until it is accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is accepted as normal.
  - Memory is not modified.
  - rsp_valid appears with the normal latency for its type, with rsp_err=1 and rsp_rdata=0.
- Undefined: rsp_err is constant 0 and misaligned address bits are ignored as described above.

Decomposition:
- Package dmem_pkg:
  - Size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
  - FSM state enum IDLE/RWAIT/RRESP/WRESP.
  - Function computing the byte-enable mask from size and lane.
- Sub-module dmem_lane_align, purely combinational:
  - Store path: replicates wdata into lanes and produces the 4-bit byte-enable.
  - Load path: extracts and extends the selected byte or halfword.
- The top level holds the RAM array, FSM and latency counter.

Test Plan:
- Word store 0x0000_00FF to addr 0x0FA0, then word load from 0x0FA0 with RD_LATENCY=1 -> rsp_valid 1 cycle after the load is accepted, rdata 0x0000_00FF.
- Byte store 0x80 to addr 0x0011, then signed byte load -> 0xFFFF_FF80; unsigned byte load -> 0x0000_0080. The other bytes of word 4 are unchanged.
- RD_LATENCY=3, two loads presented back to back -> req_ready low for 3 cycles after each acceptance, rsp_valid exactly 3 cycles after each accept.
- Address 0x1000 with DEPTH=1024 -> aliases word 0 (wrap-around); a store to 0x1000 is read back at 0x0000.
- Assert rst during RWAIT -> no rsp_valid, req_ready=1 immediately, previously stored data still readable.
- DMEM_MISALIGN_EN defined, word store to 0x0002 -> rsp_err=1, rsp_rdata=0, word 0 unchanged. Without the macro, the same store writes word 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and byte-lane helpers for pipelined_data_memory.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RWAIT = 2'd1;
  localparam logic [1:0] ST_RRESP = 2'd2;
  localparam logic [1:0] ST_WRESP = 2'd3;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << lane;
      SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = lane[0];
      default: mis = (lane != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: store replication/byte-enables and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_wdata,
  output logic [31:0] o_st_data,
  output logic [3:0]  o_st_be,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_lane,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_ext;

  always_comb begin
    o_st_be = byte_en(i_st_size, i_st_lane);
    case (i_st_size)
      SZ_BYTE: o_st_data = {4{i_st_wdata[7:0]}};
      SZ_HALF: o_st_data = {2{i_st_wdata[15:0]}};
      default: o_st_data = i_st_wdata;
    endcase
  end

  always_comb begin
    w_byte = 8'(i_ld_word >> {i_ld_lane, 3'b000});
    w_half = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];
    w_ext  = 1'b0;
    case (i_ld_size)
      SZ_BYTE: begin
        w_ext     = ~i_ld_unsigned & w_byte[7];
        o_ld_data = {{24{w_ext}}, w_byte};
      end
      SZ_HALF: begin
        w_ext     = ~i_ld_unsigned & w_half[15];
        o_ld_data = {{16{w_ext}}, w_half};
      end
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/pipelined_data_memory.sv
// Word-organised data RAM with a valid/ready load/store front end and configurable read latency.
// Define DMEM_MISALIGN_EN to flag misaligned halfword/word accesses via o_rsp_err instead of ignoring low bits.
module pipelined_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [1:0]        r_state;
  logic [1:0]        r_cnt;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rword;
  logic [1:0]        r_ld_size;
  logic [1:0]        r_ld_lane;
  logic              r_ld_unsigned;
  logic              r_ld_mis;

  logic [IDX_W-1:0]  w_idx;
  logic [1:0]        w_lane;
  logic              w_accept;
  logic              w_mis;
  logic              w_we;
  logic [31:0]       w_st_data;
  logic [3:0]        w_st_be;
  logic              w_ld_sel;
  logic [31:0]       w_ld_word;
  logic [1:0]        w_ld_size;
  logic [1:0]        w_ld_lane;
  logic              w_ld_unsigned;
  logic [31:0]       w_ld_data;
  logic              w_resp_mis;
  logic              w_resp;
  logic [1:0]        w_state_nxt;
  logic [1:0]        w_cnt_nxt;
  logic              w_unused_addr;

  // Upper address bits are deliberately dropped so accesses wrap modulo 4*DEPTH.
  assign w_idx         = i_req_addr[IDX_W+1:2];
  assign w_lane        = i_req_addr[1:0];
  assign w_unused_addr = ^i_req_addr[ADDR_W-1:IDX_W+2];
  assign w_accept      = i_req_valid & r_req_ready;

`ifdef DMEM_MISALIGN_EN
  assign w_mis = misaligned(i_req_size, w_lane);
`else
  assign w_mis = 1'b0;
`endif

  assign w_we = w_accept & i_req_write & ~w_mis;

  // Latency-1 loads respond straight from the accepting edge, so bypass the capture registers in IDLE.
  assign w_ld_sel      = (r_state == ST_IDLE);
  assign w_ld_word     = w_ld_sel ? r_mem[w_idx] : r_rword;
  assign w_ld_size     = w_ld_sel ? i_req_size : r_ld_size;
  assign w_ld_lane     = w_ld_sel ? w_lane : r_ld_lane;
  assign w_ld_unsigned = w_ld_sel ? i_req_unsigned : r_ld_unsigned;
  assign w_resp_mis    = w_ld_sel ? w_mis : r_ld_mis;
  assign w_resp        = (w_state_nxt == ST_RRESP) || (w_state_nxt == ST_WRESP);

  dmem_lane_align u_align (
    .i_st_size     (i_req_size),
    .i_st_lane     (w_lane),
    .i_st_wdata    (i_req_wdata),
    .o_st_data     (w_st_data),
    .o_st_be       (w_st_be),
    .i_ld_size     (w_ld_size),
    .i_ld_lane     (w_ld_lane),
    .i_ld_unsigned (w_ld_unsigned),
    .i_ld_word     (w_ld_word),
    .o_ld_data     (w_ld_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (i_req_write) begin
            w_state_nxt = ST_WRESP;
          end else if (RD_LATENCY == 1) begin
            w_state_nxt = ST_RRESP;
          end else begin
            w_state_nxt = ST_RWAIT;
            w_cnt_nxt   = CNT_INIT;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RWAIT: begin
        if (r_cnt <= 2'd1) begin
          w_state_nxt = ST_RRESP;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      ST_RRESP: w_state_nxt = ST_IDLE;
      ST_WRESP: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 2'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_req_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= w_resp;
      r_rsp_rdata <= ((w_state_nxt == ST_RRESP) && !w_resp_mis) ? w_ld_data : '0;
      r_rsp_err   <= w_resp & w_resp_mis;
    end
  end

  // Load word and its steering info are frozen at acceptance and held through the wait.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rword       <= '0;
      r_ld_size     <= SZ_BYTE;
      r_ld_lane     <= 2'd0;
      r_ld_unsigned <= 1'b0;
      r_ld_mis      <= 1'b0;
    end else if (w_accept && !i_req_write) begin
      r_rword       <= r_mem[w_idx];
      r_ld_size     <= i_req_size;
      r_ld_lane     <= w_lane;
      r_ld_unsigned <= i_req_unsigned;
      r_ld_mis      <= w_mis;
    end
  end

  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (w_we && w_st_be[l]) begin
        r_mem[w_idx][l*8 +: 8] <= w_st_data[l*8 +: 8];
      end
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule
